mbist_march_ctrl: RTL and testbench

MBIST_MARCH_CTRL -- requirements
Module: mbist_march_ctrl

---
 rtl/mbist_march_ctrl_if.sv | 24 ++
 rtl/mbist_march_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_mbist_march_ctrl.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/mbist_march_ctrl_if.sv
// rtl/mbist_march_ctrl_if.sv - memory-under-test bus between the MBIST controller and the RAM
interface mbist_march_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  mem_write_read;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    output mem_write_read,
    output mem_address,
    output mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_write_read,
    input  mem_address,
    input  mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mbist_march_ctrl.sv
// rtl/mbist_march_ctrl.sv - March C- MBIST controller; MBIST_STOP_ON_FAIL_EN ends the run at the first mismatch
module mbist_march_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int CAPACITY   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [2:0]            fail_element,
  output logic [15:0]           fail_count,
  mbist_march_ctrl_if.master    mem
);

`ifdef MBIST_STOP_ON_FAIL_EN
  localparam bit STOP_ON_FAIL = 1'b1;
`else
  localparam bit STOP_ON_FAIL = 1'b0;
`endif

  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(CAPACITY - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = '0;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] ALL_ZERO  = '0;
  localparam logic [DATA_WIDTH-1:0] ALL_ONES  = '1;

  typedef enum logic [3:0] {
    S_IDLE, S_M0, S_M1, S_M2, S_M3, S_M4, S_M5, S_DRAIN, S_DONE
  } state_t;

  state_t state;
  logic   drain_cnt;

  // Read-compare pipeline: stage 2 lines up with mem_rdata two cycles after the read.
  logic                  s1_valid, s2_valid;
  logic [DATA_WIDTH-1:0] s1_exp, s2_exp;
  logic [ADDR_WIDTH-1:0] s1_addr, s2_addr;
  logic [2:0]            s1_elem, s2_elem;

  logic rd_issue;
  logic elem_end;
  logic mismatch;

  function automatic logic [2:0] elem_of(state_t s);
    case (s)
      S_M1:    return 3'd1;
      S_M2:    return 3'd2;
      S_M3:    return 3'd3;
      S_M4:    return 3'd4;
      S_M5:    return 3'd5;
      default: return 3'd0;
    endcase
  endfunction

  assign rd_issue = (state inside {S_M1, S_M2, S_M3, S_M4, S_M5}) && !mem.mem_write_read;
  assign mismatch = s2_valid && (mem.mem_rdata != s2_exp);

  // Last operation of an element: the write (or sole op) at the final address of the sweep.
  always_comb begin
    elem_end = 1'b0;
    case (state)
      S_M0, S_M5: elem_end = (mem.mem_address == ADDR_LAST);
      S_M1, S_M2: elem_end = mem.mem_write_read && (mem.mem_address == ADDR_LAST);
      S_M3, S_M4: elem_end = mem.mem_write_read && (mem.mem_address == ADDR_ZERO);
      default:    elem_end = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= S_IDLE;
      drain_cnt          <= 1'b0;
      busy               <= 1'b0;
      done               <= 1'b0;
      fail               <= 1'b0;
      fail_addr          <= '0;
      fail_element       <= '0;
      fail_count         <= '0;
      mem.mem_write_read <= 1'b0;
      mem.mem_address    <= '0;
      mem.mem_wdata      <= '0;
      s1_valid           <= 1'b0;
      s2_valid           <= 1'b0;
      s1_exp             <= '0;
      s2_exp             <= '0;
      s1_addr            <= '0;
      s2_addr            <= '0;
      s1_elem            <= '0;
      s2_elem            <= '0;
    end else begin
      s1_valid <= rd_issue;
      s1_exp   <= (state == S_M2 || state == S_M4) ? ALL_ONES : ALL_ZERO;
      s1_addr  <= mem.mem_address;
      s1_elem  <= elem_of(state);
      s2_valid <= s1_valid;
      s2_exp   <= s1_exp;
      s2_addr  <= s1_addr;
      s2_elem  <= s1_elem;

      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state              <= S_M0;
            busy               <= 1'b1;
            done               <= 1'b0;
            fail               <= 1'b0;
            fail_addr          <= '0;
            fail_element       <= '0;
            fail_count         <= '0;
            mem.mem_write_read <= 1'b1;
            mem.mem_address    <= ADDR_ZERO;
            mem.mem_wdata      <= ALL_ZERO;
          end
        end
        S_M0: begin
          if (elem_end) begin
            state              <= S_M1;
            mem.mem_write_read <= 1'b0;
            mem.mem_address    <= ADDR_ZERO;
            mem.mem_wdata      <= ALL_ONES;
          end else begin
            mem.mem_address <= mem.mem_address + ADDR_ONE;
          end
        end
        S_M1, S_M2, S_M3, S_M4: begin
          if (elem_end) begin
            mem.mem_write_read <= 1'b0;
            case (state)
              S_M1: begin
                state           <= S_M2;
                mem.mem_address <= ADDR_ZERO;
                mem.mem_wdata   <= ALL_ZERO;
              end
              S_M2: begin
                state           <= S_M3;
                mem.mem_address <= ADDR_LAST;
                mem.mem_wdata   <= ALL_ONES;
              end
              S_M3: begin
                state           <= S_M4;
                mem.mem_address <= ADDR_LAST;
                mem.mem_wdata   <= ALL_ZERO;
              end
              default: begin
                state           <= S_M5;
                mem.mem_address <= ADDR_ZERO;
                mem.mem_wdata   <= ALL_ZERO;
              end
            endcase
          end else if (!mem.mem_write_read) begin
            mem.mem_write_read <= 1'b1;
          end else begin
            mem.mem_write_read <= 1'b0;
            if (state == S_M3 || state == S_M4)
              mem.mem_address <= mem.mem_address - ADDR_ONE;
            else
              mem.mem_address <= mem.mem_address + ADDR_ONE;
          end
        end
        S_M5: begin
          if (elem_end) begin
            state           <= S_DRAIN;
            drain_cnt       <= 1'b0;
            mem.mem_address <= ADDR_ZERO;
            mem.mem_wdata   <= ALL_ZERO;
          end else begin
            mem.mem_address <= mem.mem_address + ADDR_ONE;
          end
        end
        S_DRAIN: begin
          drain_cnt <= 1'b1;
          if (drain_cnt) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase

      // Placed after the FSM so an early stop overrides whatever the element step chose.
      if (mismatch) begin
        if (!fail) begin
          fail         <= 1'b1;
          fail_addr    <= s2_addr;
          fail_element <= s2_elem;
        end
        if (fail_count != 16'hFFFF)
          fail_count <= fail_count + 16'd1;
        if (STOP_ON_FAIL) begin
          state              <= S_DONE;
          busy               <= 1'b0;
          done               <= 1'b1;
          mem.mem_write_read <= 1'b0;
          mem.mem_address    <= '0;
          mem.mem_wdata      <= '0;
          s1_valid           <= 1'b0;
          s2_valid           <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// tb/tb_mbist_march_ctrl.sv - scoreboard bench for mbist_march_ctrl with a faultable RAM model
module tb_mbist_march_ctrl;
  localparam int DW  = 8;
  localparam int AW  = 4;
  localparam int CAP = 8;
  localparam int RUN_DONE = 10 * CAP + 2;

`ifdef MBIST_STOP_ON_FAIL_EN
  localparam bit STOP_MODE = 1'b1;
`else
  localparam bit STOP_MODE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy;
  logic          done;
  logic          fail;
  logic [AW-1:0] fail_addr;
  logic [2:0]    fail_element;
  logic [15:0]   fail_count;

  always #5 clk = ~clk;

  mbist_march_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) mem_bus();

  mbist_march_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CAPACITY(CAP)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .fail         (fail),
    .fail_addr    (fail_addr),
    .fail_element (fail_element),
    .fail_count   (fail_count),
    .mem          (mem_bus)
  );

  // RAM: address registered once and read data registered once (2-cycle read); wdata registered once.
  logic [DW-1:0] mem_arr [2**AW];
  logic [AW-1:0] addr_q = '0;
  logic [DW-1:0] wdata_q = '0;
  logic [DW-1:0] rdata_q = '0;
  logic          fault_en = 1'b0;

  always @(posedge clk) begin
    addr_q  <= mem_bus.mem_address;
    wdata_q <= mem_bus.mem_wdata;
    rdata_q <= mem_arr[addr_q];
    if (mem_bus.mem_write_read) begin
      // Bit 1 of address 5 cannot fall from 1 to 0 while the fault is enabled.
      if (fault_en && mem_bus.mem_address == AW'(5))
        mem_arr[mem_bus.mem_address] <= wdata_q | (mem_arr[mem_bus.mem_address] & 8'h02);
      else
        mem_arr[mem_bus.mem_address] <= wdata_q;
    end
  end
  assign mem_bus.mem_rdata = rdata_q;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } op_t;

  typedef struct {
    int            cyc;
    logic          fail;
    logic [AW-1:0] addr;
    logic [2:0]    elem;
    logic [15:0]   cnt;
  } res_t;

  op_t  op_q[$];
  res_t res_q[$];
  op_t  mon_op;
  res_t mon_res;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc_p    = 0;
  int run_t0   = 0;
  int res_pops = 0;
  logic [DW-1:0] prev_wdata = '0;
  logic          prev_done  = 1'b0;

  always @(posedge clk) cyc_p <= cyc_p + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic push_ops();
    int a;
    logic [DW-1:0] wval;
    for (int e = 0; e < 6; e++) begin
      for (int i = 0; i < CAP; i++) begin
        a    = (e == 3 || e == 4) ? CAP - 1 - i : i;
        wval = (e == 1 || e == 3) ? '1 : '0;
        if (e != 0) op_q.push_back('{1'b0, AW'(a), '0});
        if (e != 5) op_q.push_back('{1'b1, AW'(a), wval});
      end
    end
  endtask

  task automatic start_run(input int dc, input logic f, input logic [AW-1:0] fa,
                           input logic [2:0] fe, input logic [15:0] fc);
    push_ops();
    res_q.push_back('{dc, f, fa, fe, fc});
    run_t0 = cyc_p + 1;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("start_busy", 32'(busy), 32'd1);
    check_eq("start_clears_done", 32'(done), 32'd0);
    check_eq("start_clears_fail", 32'(fail), 32'd0);
    check_eq("start_clears_count", 32'(fail_count), 32'd0);
  endtask

  task automatic wait_done();
    int n0 = res_pops;
    int k  = 0;
    while (res_pops == n0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (res_pops == n0) check_eq("done_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_fail", 32'(fail), 32'd0);
    check_eq("rst_fail_addr", 32'(fail_addr), 32'd0);
    check_eq("rst_fail_element", 32'(fail_element), 32'd0);
    check_eq("rst_fail_count", 32'(fail_count), 32'd0);
    check_eq("rst_mem_wr", 32'(mem_bus.mem_write_read), 32'd0);
    check_eq("rst_mem_addr", 32'(mem_bus.mem_address), 32'd0);
    check_eq("rst_mem_wdata", 32'(mem_bus.mem_wdata), 32'd0);
  endtask

  // Monitor: pop one expected op per busy cycle, pop a run result when done rises.
  always @(negedge clk) begin
    if (busy && op_q.size() > 0) begin
      mon_op = op_q.pop_front();
      check_eq("op_wr", 32'(mem_bus.mem_write_read), 32'(mon_op.wr));
      check_eq("op_addr", 32'(mem_bus.mem_address), 32'(mon_op.addr));
      if (mon_op.wr) check_eq("wdata_ahead", 32'(prev_wdata), 32'(mon_op.data));
    end
    if (done && !prev_done) begin
      if (res_q.size() == 0) begin
        check_eq("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_res = res_q.pop_front();
        check_eq("done_cycle", 32'(cyc_p - run_t0), 32'(mon_res.cyc));
        check_eq("fail", 32'(fail), 32'(mon_res.fail));
        check_eq("fail_addr", 32'(fail_addr), 32'(mon_res.addr));
        check_eq("fail_element", 32'(fail_element), 32'(mon_res.elem));
        check_eq("fail_count", 32'(fail_count), 32'(mon_res.cnt));
        check_eq("done_busy", 32'(busy), 32'd0);
        check_eq("done_mem_wr", 32'(mem_bus.mem_write_read), 32'd0);
      end
      if (STOP_MODE) op_q.delete();
      else check_eq("ops_left", 32'(op_q.size()), 32'd0);
      res_pops++;
    end
    prev_wdata = mem_bus.mem_wdata;
    prev_done  = done;
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 2**AW; i++) mem_arr[i] = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs();

    // rst wins over start in the same cycle
    start = 1'b1;
    @(negedge clk);
    check_eq("rst_prio_busy", 32'(busy), 32'd0);
    check_eq("rst_prio_wr", 32'(mem_bus.mem_write_read), 32'd0);
    start = 1'b0;
    rst   = 1'b0;
    @(negedge clk);

    // fault-free run
    start_run(RUN_DONE, 1'b0, '0, '0, 16'd0);
    wait_done();

    // transition fault at address 5, bit 1
    fault_en = 1'b1;
    if (STOP_MODE) start_run(47, 1'b1, AW'(5), 3'd3, 16'd1);
    else           start_run(RUN_DONE, 1'b1, AW'(5), 3'd3, 16'd2);
    wait_done();
    fault_en = 1'b0;

    // restart from DONE, with a start pulse during M1 that must be ignored
    start_run(RUN_DONE, 1'b0, '0, '0, 16'd0);
    repeat (12) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();

    // reset in the middle of M2
    start_run(RUN_DONE, 1'b0, '0, '0, 16'd0);
    repeat (30) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs();
    op_q.delete();
    res_q.delete();
    rst = 1'b0;
    @(negedge clk);

    start_run(RUN_DONE, 1'b0, '0, '0, 16'd0);
    wait_done();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
